// File: rtl/sf_multiplier_seq.sv
// Sequential scale-field multiplier: shift-add over the mantissa magnitudes, then a one-clock renormalise/saturate.
// Optional build macro SFMUL_ROUND_EN: round half-up on every normalising right shift (default: truncate).
module sf_multiplier_seq #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned SF_BITS = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             overflow
);

    localparam int unsigned MW     = WIDTH - SF_BITS;
    localparam int unsigned PW     = 2 * MW;
    localparam int unsigned EW     = PW + 1;
    localparam int unsigned SPW    = SF_BITS + 1;
    localparam int unsigned SF_MAX = (1 << SF_BITS) - 1;
    localparam int unsigned CW     = $clog2(MW);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_NORM = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [CW-1:0]    r_cnt;
    logic [PW-1:0]    r_mcand;
    logic [PW-1:0]    r_prod;
    logic [MW:0]      r_mplier;
    logic             r_sign;
    logic [SPW-1:0]   r_sfp;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             r_overflow;
    logic [WIDTH-1:0] r_result;

    logic w_accept;
    logic w_step;
    logic w_load;
    logic w_last;

    // Operand decode: magnitudes carry one extra bit so the most-negative mantissa cannot wrap
    logic [MW:0]    w_ext_a;
    logic [MW:0]    w_ext_b;
    logic [MW:0]    w_mag_a;
    logic [MW:0]    w_mag_b;
    logic [SPW-1:0] w_sf_sum;

    assign w_ext_a  = {a[WIDTH-1], a[WIDTH-1:SF_BITS]};
    assign w_ext_b  = {b[WIDTH-1], b[WIDTH-1:SF_BITS]};
    assign w_mag_a  = a[WIDTH-1] ? ((~w_ext_a) + (MW+1)'(1)) : w_ext_a;
    assign w_mag_b  = b[WIDTH-1] ? ((~w_ext_b) + (MW+1)'(1)) : w_ext_b;
    assign w_sf_sum = SPW'(a[SF_BITS-1:0]) + SPW'(b[SF_BITS-1:0]);
    assign w_last   = (r_cnt == CW'(MW - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (in_valid && r_in_ready) w_state_nxt = S_MUL;
            S_MUL:   if (w_last) w_state_nxt = S_NORM;
            S_NORM:  w_state_nxt = S_DONE;
            S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_accept = 1'b0;
        w_step   = 1'b0;
        w_load   = 1'b0;
        case (r_state)
            S_IDLE:  w_accept = in_valid && r_in_ready;
            S_MUL:   w_step   = 1'b1;
            S_NORM:  w_load   = 1'b1;
            default: ;
        endcase
    end

    // Signed product and the largest scale not above min(sf_p, SF_MAX) whose mantissa fits
    logic signed [EW-1:0] w_p_ext;
    logic signed [EW-1:0] w_val;
    logic [SPW-1:0]       w_sf_cap;
    logic [SPW-1:0]       w_shift;
    logic [EW-MW:0]       w_top;
    logic                 w_fit;
    logic [MW-1:0]        w_norm_m;
    logic [SF_BITS-1:0]   w_norm_sf;
    logic                 w_norm_ovf;

    assign w_p_ext  = r_sign ? $signed((~{1'b0, r_prod}) + EW'(1)) : $signed({1'b0, r_prod});
    assign w_sf_cap = (r_sfp > SPW'(SF_MAX)) ? SPW'(SF_MAX) : r_sfp;

    always_comb begin
        w_fit      = 1'b0;
        w_norm_m   = '0;
        w_norm_sf  = '0;
        w_norm_ovf = 1'b0;
        w_shift    = '0;
        w_val      = '0;
        w_top      = '0;
        for (int unsigned s = 0; s <= SF_MAX; s++) begin
            if (SPW'(s) <= w_sf_cap) begin
                w_shift = r_sfp - SPW'(s);
`ifdef SFMUL_ROUND_EN
                w_val = w_p_ext + $signed((w_shift != '0) ? (EW'(1) << (w_shift - SPW'(1))) : EW'(0));
                w_val = w_val >>> w_shift;
`else
                w_val = w_p_ext >>> w_shift;
`endif
                w_top = w_val[EW-1:MW-1];
                if ((&w_top) || !(|w_top)) begin
                    w_fit     = 1'b1;
                    w_norm_m  = w_val[MW-1:0];
                    w_norm_sf = SF_BITS'(s);
                end
            end
        end
        if (!w_fit) begin
            w_norm_ovf = 1'b1;
            w_norm_sf  = '0;
            w_norm_m   = w_p_ext[EW-1] ? {1'b1, {(MW-1){1'b0}}} : {1'b0, {(MW-1){1'b1}}};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= '0;
            r_mcand     <= '0;
            r_prod      <= '0;
            r_mplier    <= '0;
            r_sign      <= 1'b0;
            r_sfp       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_overflow  <= 1'b0;
            r_result    <= '0;
        end else begin
            r_in_ready  <= (w_state_nxt == S_IDLE);
            r_out_valid <= (w_state_nxt == S_DONE);
            if (w_accept) begin
                r_mcand  <= PW'(w_mag_a);
                r_mplier <= w_mag_b;
                r_prod   <= '0;
                r_sign   <= a[WIDTH-1] ^ b[WIDTH-1];
                r_sfp    <= w_sf_sum;
                r_cnt    <= '0;
            end else if (w_step) begin
                if (r_mplier[0]) r_prod <= r_prod + r_mcand;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt + CW'(1);
            end
            if (w_load) begin
                r_result   <= {w_norm_m, w_norm_sf};
                r_overflow <= w_norm_ovf;
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_sf_multiplier_seq.sv
// Bench for sf_multiplier_seq (WIDTH=16, SF_BITS=3): directed vectors, an integer reference model
// and a per-cycle handshake/latency tracker.
module tb_sf_multiplier_seq;

    localparam int MW = 13;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic        overflow;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [15:0] r;
        logic        o;
    } exp_t;
    exp_t exp_q[$];

    sf_multiplier_seq #(.WIDTH(16), .SF_BITS(3)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string nm);
        checks++;
        failures++;
        $display("FAIL %s (bound expired) at %0t", nm, $time);
    endtask

    // Reference: value arithmetic on integers, scale chosen as the largest that still fits
    function automatic void model(input logic [15:0] x, input logic [15:0] y,
                                  output logic [15:0] r, output logic o);
        longint mx, my, p, m, mm;
        int     sfp, cap, sh, sfo;
        bit     found;
        mx    = longint'($signed(x[15:3]));
        my    = longint'($signed(y[15:3]));
        sfp   = int'(x[2:0]) + int'(y[2:0]);
        p     = mx * my;
        cap   = (sfp > 7) ? 7 : sfp;
        found = 1'b0;
        mm    = 0;
        sfo   = 0;
        o     = 1'b0;
        for (int s = cap; s >= 0; s--) begin
            if (!found) begin
                sh = sfp - s;
`ifdef SFMUL_ROUND_EN
                m = (p + ((sh > 0) ? (longint'(1) << (sh - 1)) : longint'(0))) >>> sh;
`else
                m = p >>> sh;
`endif
                if (m >= -4096 && m <= 4095) begin
                    found = 1'b1;
                    mm    = m;
                    sfo   = s;
                end
            end
        end
        if (!found) begin
            o   = 1'b1;
            sfo = 0;
            mm  = (p < 0) ? -4096 : 4095;
        end
        r = {mm[12:0], 3'(sfo)};
    endfunction

    // Per-cycle tracker: busy from accept until the edge after the result is taken
    bit pend_rst = 1'b1;
    bit pend_acc = 1'b0;
    bit pend_hs  = 1'b0;
    bit busy     = 1'b0;
    int cnt      = 0;

    always @(negedge clk) begin
        logic [15:0] mr;
        logic        mo;
        if (pend_rst) begin
            busy = 1'b0;
            exp_q.delete();
        end else if (pend_acc) begin
            busy = 1'b1;
            cnt  = 1;
        end else if (pend_hs) begin
            busy = 1'b0;
            if (exp_q.size() > 0) exp_q.delete(0);
        end else if (busy) begin
            cnt++;
        end
        if (pend_rst) begin
            chk("reset_result", 32'(result), 32'h0);
            chk("reset_overflow", 32'(overflow), 32'h0);
        end
        chk("in_ready", 32'(in_ready), 32'(!busy));
        chk("out_valid", 32'(out_valid), 32'(busy && cnt >= MW + 2));
        if (out_valid && busy) begin
            if (exp_q.size() == 0) begin
                fail_now("result_without_request");
            end else begin
                chk("result_model", 32'(result), 32'(exp_q[0].r));
                chk("overflow_model", 32'(overflow), 32'(exp_q[0].o));
            end
        end
        pend_rst = rst;
        pend_acc = !rst && in_valid && in_ready;
        pend_hs  = !rst && out_valid && out_ready;
        if (pend_acc) begin
            model(a, b, mr, mo);
            exp_q.push_back('{mr, mo});
        end
    end

    localparam int NV = 9;
    logic [15:0] va[NV];
    logic [15:0] vb[NV];
    logic [15:0] vr[NV];
    logic        vo[NV];

    task automatic run_op(input int idx, input int hold);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 50; n++) begin
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        if (!ok) fail_now($sformatf("op%0d_wait_in_ready", idx));
        a = va[idx];
        b = vb[idx];
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        ok = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_now($sformatf("op%0d_wait_out_valid", idx));
        for (int h = 0; h < hold; h++) begin
            chk("hold_in_ready", 32'(in_ready), 32'h0);
            chk("hold_result", 32'(result), 32'(vr[idx]));
            @(posedge clk); #1;
        end
        chk($sformatf("op%0d_result", idx), 32'(result), 32'(vr[idx]));
        chk($sformatf("op%0d_overflow", idx), 32'(overflow), 32'(vo[idx]));
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog_timeout at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] mr;
        logic        mo;
        int          rises;
        int          last;
        int          cyc;
        bit          prev;

        // 3.5*5.25, -6.5*4, 6.75*-4, renormalise, two saturations, zero, most-negative cases, truncation
        va[0] = 16'h0039; vb[0] = 16'h02A4; vr[0] = 16'h1265; vo[0] = 1'b0;
        va[1] = 16'hFF99; vb[1] = 16'h0020; vr[1] = 16'hFE61; vo[1] = 1'b0;
        va[2] = 16'h00DA; vb[2] = 16'hFFE0; vr[2] = 16'hFCA2; vo[2] = 1'b0;
        va[3] = 16'h051D; vb[3] = 16'h068D; vr[3] = 16'h428E; vo[3] = 1'b0;
        va[4] = 16'h7FF8; vb[4] = 16'h7FF8; vr[4] = 16'h7FF8; vo[4] = 1'b1;
        va[5] = 16'h7FF8; vb[5] = 16'h8000; vr[5] = 16'h8000; vo[5] = 1'b1;
        va[6] = 16'h0007; vb[6] = 16'h002F; vr[6] = 16'h0007; vo[6] = 1'b0;
        va[7] = 16'h8000; vb[7] = 16'h0008; vr[7] = 16'h8000; vo[7] = 1'b0;
        va[8] = 16'h8000; vb[8] = 16'hFFF8; vr[8] = 16'h7FF8; vo[8] = 1'b1;

        for (int i = 0; i < NV; i++) begin
            model(va[i], vb[i], mr, mo);
            chk($sformatf("model_pin_%0d", i), 32'({mr, mo}), 32'({vr[i], vo[i]}));
        end
        model(16'hFFEF, 16'h000F, mr, mo);
        chk("model_pin_trunc", 32'({mr, mo}), 32'({16'hFFFF, 1'b0}));

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("post_reset_in_ready", 32'(in_ready), 32'h1);
        chk("post_reset_out_valid", 32'(out_valid), 32'h0);

        for (int i = 0; i < NV; i++) run_op(i, (i == 0) ? 5 : 0);

        // Abort mid-multiply
        a = va[2];
        b = vb[2];
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_out_valid", 32'(out_valid), 32'h0);
        chk("abort_in_ready", 32'(in_ready), 32'h1);
        repeat (MW + 5) @(posedge clk);
        #1;
        chk("abort_no_result", 32'(out_valid), 32'h0);

        // Back-to-back with the consumer always ready
        a = va[3];
        b = vb[3];
        in_valid  = 1'b1;
        out_ready = 1'b1;
        rises = 0;
        last  = -1;
        cyc   = 0;
        prev  = 1'b0;
        for (int n = 0; n < 200 && rises < 3; n++) begin
            @(posedge clk); #1;
            cyc++;
            if (out_valid && !prev) begin
                if (last >= 0) chk("b2b_spacing", 32'(cyc - last), 32'(MW + 3));
                last = cyc;
                rises++;
                if (rises == 3) in_valid = 1'b0;
            end
            prev = out_valid;
        end
        if (rises < 3) fail_now("b2b_rises");
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
